// File: rtl/maze_mem_pkg.sv
// Shared widths, memory command codes, cell codes and FSM encoding for the maze memory arbiter.
package maze_mem_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 2;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  localparam logic [DATA_W-1:0] CELL_PATH = 2'd0;
  localparam logic [DATA_W-1:0] CELL_WALL = 2'd1;
  localparam logic [DATA_W-1:0] CELL_GOAL = 2'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Granted request held through the ACCESS cycle; the address lives in the mem_address register.
  typedef struct packed {
    logic              port;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic r_last_grant;

  // One-hot (or zero) grant; a lone requester always wins, ties go against the last winner.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner of each accepted grant; reset favours port 0 on the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      r_last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Sole master of the 64x2-bit maze memory, sharing it between the renderer (port 0, read-only)
// and game logic (port 1, read/write) with one access every two cycles at most.
module maze_mem_arbiter
  import maze_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ready,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_data,
  input  logic              p1_valid,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_command,
  inout  wire  [DATA_W-1:0] mem_data
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_hs;
  req_t                w_req_sel;
  logic [ADDR_W-1:0]   w_addr_sel;
  req_t                r_req;
  logic [ADDR_W-1:0]   r_mem_address;
  logic                r_mem_command;
  logic [DATA_W-1:0]   w_rd_data;
  logic                r_p0_rsp_valid;
  logic                r_p1_rsp_valid;
  logic [DATA_W-1:0]   r_p0_rsp_data;
  logic [DATA_W-1:0]   r_p1_rsp_data;

  // Requests are only visible to the arbiter while the memory is free.
  assign w_req = (r_state == ST_IDLE) ? {p1_valid, p0_valid} : 2'b00;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .advance (w_hs),
    .gnt     (w_gnt)
  );

  // Mux the granted port's request; port 0 can only read.
  always_comb begin
    w_req_sel.port  = w_gnt[1];
    w_req_sel.we    = w_gnt[1] & p1_we;
    w_req_sel.wdata = p1_wdata;
    w_addr_sel      = w_gnt[1] ? p1_addr : p0_addr;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    p0_ready    = 1'b0;
    p1_ready    = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        p0_ready = w_gnt[0];
        p1_ready = w_gnt[1];
        w_hs     = |w_gnt;
        if (w_hs) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the granted request and launch the memory cycle; command falls back to read otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req         <= '0;
      r_mem_address <= '0;
      r_mem_command <= CMD_READ;
    end else if (w_hs) begin
      r_req         <= w_req_sel;
      r_mem_address <= w_addr_sel;
      r_mem_command <= w_req_sel.we ? CMD_WRITE : CMD_READ;
    end else begin
      r_mem_command <= CMD_READ;
    end
  end

  // Writes complete with the value written; reads take whatever the memory drives.
  assign w_rd_data = r_req.we ? r_req.wdata : mem_data;

  // Capture the completion at the edge that ends ACCESS and pulse the owning port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p0_rsp_valid <= 1'b0;
      r_p1_rsp_valid <= 1'b0;
      r_p0_rsp_data  <= CELL_PATH;
      r_p1_rsp_data  <= CELL_PATH;
    end else begin
      r_p0_rsp_valid <= 1'b0;
      r_p1_rsp_valid <= 1'b0;
      if (r_state == ST_ACCESS) begin
        if (r_req.port) begin
          r_p1_rsp_valid <= 1'b1;
          r_p1_rsp_data  <= w_rd_data;
        end else begin
          r_p0_rsp_valid <= 1'b1;
          r_p0_rsp_data  <= w_rd_data;
        end
      end
    end
  end

  // Bus enable and write command come from the same register, so a turnaround cannot collide.
  assign mem_data     = (r_mem_command == CMD_WRITE) ? r_req.wdata : {DATA_W{1'bz}};
  assign mem_address  = r_mem_address;
  assign mem_command  = r_mem_command;
  assign p0_rsp_valid = r_p0_rsp_valid;
  assign p1_rsp_valid = r_p1_rsp_valid;
  assign p0_rsp_data  = r_p0_rsp_data;
  assign p1_rsp_data  = r_p1_rsp_data;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Bench for maze_mem_arbiter: maze memory device, request-level reference model, directed and random steps.
module tb_maze_mem_arbiter;
  import maze_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              p0_valid, p1_valid, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid;
  logic [DATA_W-1:0] p0_rsp_data, p1_rsp_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_command;
  wire  [DATA_W-1:0] mem_data;

  maze_mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_valid     (p0_valid),
    .p0_addr      (p0_addr),
    .p0_ready     (p0_ready),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_data  (p0_rsp_data),
    .p1_valid     (p1_valid),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_ready     (p1_ready),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_data  (p1_rsp_data),
    .mem_address  (mem_address),
    .mem_command  (mem_command),
    .mem_data     (mem_data)
  );

  always #10 clk = ~clk;

  // Initial maze: border walls, a few interior walls, goal at cell 48.
  function automatic logic [1:0] image(input int i);
    int r;
    int c;
    r = i / 8;
    c = i % 8;
    if (i == 48) return CELL_GOAL;
    if (r == 0 || r == 7 || c == 0 || c == 7) return CELL_WALL;
    if ((r % 2 == 0) && (c % 3 == 0)) return CELL_WALL;
    return CELL_PATH;
  endfunction

  // Memory device: drives the bus whenever in read mode, writes on every edge with command=0.
  logic [1:0] dev_mem [64];
  logic       dev_load = 1'b1;
  assign mem_data = (mem_command == CMD_READ) ? dev_mem[mem_address] : 2'bzz;
  always @(posedge clk) begin
    if (dev_load) begin
      for (int i = 0; i < 64; i++) dev_mem[i] <= image(i);
    end else if (mem_command == CMD_WRITE) begin
      dev_mem[mem_address] <= mem_data;
    end
  end

  // Reference model at transaction level.
  typedef struct packed {
    logic       v;
    logic       port;
    logic       we;
    logic [5:0] a;
    logic [1:0] d;
  } op_t;

  logic [1:0] ref_mem [64];
  op_t        m_acc, m_rsp;
  bit         m_last;
  logic [1:0] m_hold0, m_hold1;
  bit         d0s, d1s;
  int         cyc;
  int         tests = 0;
  int         fails = 0;
  int         n;
  int         last_cyc;
  int         order [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_acc   = '0;
    m_rsp   = '0;
    m_last  = 1'b1;
    m_hold0 = 2'd0;
    m_hold1 = 2'd0;
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model, return just after the edge.
  task automatic cycle();
    logic e0, e1;
    op_t  nop;
    @(negedge clk);
    cyc++;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!m_acc.v) begin
      if (p0_valid && p1_valid) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = p0_valid;
        e1 = p1_valid;
      end
    end
    d0s = p0_ready && p0_valid;
    d1s = p1_ready && p1_valid;
    chk("p0_ready", 32'(p0_ready), 32'(e0));
    chk("p1_ready", 32'(p1_ready), 32'(e1));
    chk("p0_rsp_valid", 32'(p0_rsp_valid), 32'(m_rsp.v && !m_rsp.port));
    chk("p1_rsp_valid", 32'(p1_rsp_valid), 32'(m_rsp.v && m_rsp.port));
    if (m_rsp.v) begin
      if (m_rsp.port) m_hold1 = m_rsp.d;
      else            m_hold0 = m_rsp.d;
    end
    chk("p0_rsp_data", 32'(p0_rsp_data), 32'(m_hold0));
    chk("p1_rsp_data", 32'(p1_rsp_data), 32'(m_hold1));
    chk("mem_command", 32'(mem_command), 32'(!(m_acc.v && m_acc.we)));
    if (m_acc.v) chk("mem_address", 32'(mem_address), 32'(m_acc.a));
    if (m_acc.v && m_acc.we) chk("bus_write", 32'(mem_data), 32'(m_acc.d));
    else                     chk("bus_read", 32'(mem_data), 32'(dev_mem[mem_address]));
    nop = '0;
    if (e0 || e1) begin
      nop.v    = 1'b1;
      nop.port = e1;
      nop.we   = e1 && p1_we;
      nop.a    = e1 ? p1_addr : p0_addr;
      nop.d    = nop.we ? p1_wdata : ref_mem[nop.a];
      if (nop.we) ref_mem[nop.a] = p1_wdata;
      m_last = e1;
    end
    m_rsp = m_acc;
    m_acc = nop;
    @(posedge clk);
    #1;
  endtask

  task automatic req(input bit port, input bit we, input logic [5:0] a, input logic [1:0] d);
    int k;
    if (!port) begin
      p0_valid = 1'b1; p0_addr = a;
    end else begin
      p1_valid = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
    end
    k = 0;
    do begin
      cycle();
      k++;
    end while (!(port ? d1s : d0s) && k < 10);
    chk("accept", 32'(port ? d1s : d0s), 32'd1);
    if (!port) p0_valid = 1'b0;
    else       p1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    p0_valid = 1'b0; p0_addr = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    cyc = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = image(i);
    model_reset();
    @(posedge clk);
    #1;
    dev_load = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset.
    repeat (10) cycle();
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_command", 32'(mem_command), 32'd1);

    // Whole maze image through port 0.
    for (int i = 0; i < 64; i++) req(1'b0, 1'b0, 6'(i), 2'd0);
    repeat (2) cycle();

    // Goal cell read.
    req(1'b0, 1'b0, 6'd48, 2'd0);
    repeat (2) cycle();
    chk("read48", 32'(p0_rsp_data), 32'(CELL_GOAL));

    // Write 12 from game logic, then renderer reads it back.
    req(1'b1, 1'b1, 6'd12, 2'd3);
    repeat (2) cycle();
    chk("write12_rsp", 32'(p1_rsp_data), 32'd3);
    req(1'b0, 1'b0, 6'd12, 2'd0);
    repeat (2) cycle();
    chk("read12", 32'(p0_rsp_data), 32'd3);

    // Write 20 immediately followed by a read of 21 (write->read turnaround).
    req(1'b1, 1'b1, 6'd20, 2'd2);
    req(1'b0, 1'b0, 6'd21, 2'd0);
    repeat (2) cycle();
    chk("read21_unchanged", 32'(p0_rsp_data), 32'd0);
    req(1'b0, 1'b0, 6'd20, 2'd0);
    repeat (2) cycle();
    chk("read20", 32'(p0_rsp_data), 32'd2);

    // Reset lands on the ACCESS cycle of a write to 13.
    p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 6'd13; p1_wdata = 2'd1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!d1s && n < 10);
    chk("accept13", 32'(d1s), 32'd1);
    p1_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    model_reset();
    rst_n = 1'b1;
    chk("midrst_cmd", 32'(mem_command), 32'd1);
    chk("midrst_addr", 32'(mem_address), 32'd0);
    chk("midrst_p1_rsp_valid", 32'(p1_rsp_valid), 32'd0);
    chk("midrst_p1_rsp_data", 32'(p1_rsp_data), 32'd0);
    chk("midrst_p0_rsp_data", 32'(p0_rsp_data), 32'd0);
    repeat (2) cycle();
    req(1'b0, 1'b0, 6'd13, 2'd0);
    repeat (2) cycle();
    chk("read13_committed", 32'(p0_rsp_data), 32'd1);

    // Both ports valid continuously: strict alternation starting with port 0.
    do_reset();
    p0_valid = 1'b1; p0_addr = 6'($urandom);
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 6'($urandom); p1_wdata = 2'($urandom);
    n = 0;
    last_cyc = -1;
    while (order.size() < 8 && n < 40) begin
      cycle();
      n++;
      if (d0s || d1s) begin
        order.push_back(d1s ? 1 : 0);
        if (last_cyc >= 0) chk("rr_interval", 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        if (d0s) begin
          p0_addr = 6'($urandom);
        end else begin
          p1_addr = 6'($urandom); p1_we = 1'($urandom); p1_wdata = 2'($urandom);
        end
      end
    end
    chk("rr_count", 32'(order.size()), 32'd8);
    for (int k = 0; k < order.size(); k++) chk("rr_order", 32'(order[k]), 32'(k % 2));

    // Random traffic, including withdrawn requests.
    for (int k = 0; k < 400; k++) begin
      cycle();
      if (d0s || !p0_valid) begin
        p0_valid = ($urandom % 3) != 0; p0_addr = 6'($urandom);
      end else if ($urandom % 8 == 0) begin
        p0_valid = 1'b0;
      end
      if (d1s || !p1_valid) begin
        p1_valid = ($urandom % 3) != 0; p1_we = 1'($urandom);
        p1_addr = 6'($urandom); p1_wdata = 2'($urandom);
      end else if ($urandom % 8 == 0) begin
        p1_valid = 1'b0;
      end
    end
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
